// File: rtl/aes_stream_packer.sv
// aes_stream_packer: packs 32-bit stream words into 128-bit AES blocks, starts the
// core, captures its result and serialises it back out as 32-bit words with byte
// strobes. A message of data_size_i bytes is cut into 16-byte blocks; the final
// partial word is zero-padded above the last valid byte lane.
// The byte/word arithmetic (rem % 4, up to four words per block) is written for the
// default 32-bit word, 4-word block configuration.
module aes_stream_packer #(
    parameter int WORD_W = 32,
    parameter int NWORDS = 4,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       start_i,
    input  logic [CNT_W-1:0]           data_size_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WORD_W-1:0]          in_data_i,
    output logic                       core_start_o,
    output logic [WORD_W*NWORDS-1:0]   core_block_o,
    input  logic                       core_valid_i,
    input  logic [WORD_W*NWORDS-1:0]   core_result_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WORD_W-1:0]          out_data_o,
    output logic [WORD_W/8-1:0]        out_strb_o,
    output logic                       block_done_o,
    output logic                       done_o,
    output logic                       busy_o
);

    localparam int STRB_W = WORD_W / 8;
    localparam int BLK_W  = WORD_W * NWORDS;

    // Bytes per block, and the byte count above which a block is certainly full.
    localparam logic [CNT_W-1:0] BLK_BYTES = CNT_W'(STRB_W * NWORDS);
    localparam logic [CNT_W-1:0] FULL_LIM  = CNT_W'(STRB_W * (NWORDS - 1));
    localparam logic [1:0]       LAST_SLOT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FILL       = 3'd1,
        ST_CORE_START = 3'd2,
        ST_CORE_WAIT  = 3'd3,
        ST_DRAIN      = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    state_t                           state_r;
    logic [CNT_W-1:0]                 rem_r;
    logic [1:0]                       word_cnt_r;
    logic [NWORDS-1:0][WORD_W-1:0]    block_r;
    logic [NWORDS-1:0][WORD_W-1:0]    result_r;

    logic [2:0]                       nw_s;
    logic [1:0]                       tail_s;
    logic                             last_blk_s;
    logic                             word_last_s;
    logic                             next_last_s;
    logic                             first_last_s;
    logic [STRB_W-1:0]                in_strb_s;
    logic [WORD_W-1:0]                in_word_s;
    logic [STRB_W-1:0]                first_strb_s;
    logic [STRB_W-1:0]                next_strb_s;
    logic [1:0]                       wr_slot_s;
    logic [1:0]                       rd_slot_s;
    logic [CNT_W-1:0]                 rem_nx_s;

    // Byte strobe of a word: only the low `tail` lanes on the partial final word.
    function automatic logic [STRB_W-1:0] lane_strb(input logic partial, input logic [1:0] tail);
        logic [STRB_W-1:0] s;
        s = {STRB_W{1'b1}};
        if (partial) begin
            case (tail)
                2'd1:    s = 4'b0001;
                2'd2:    s = 4'b0011;
                2'd3:    s = 4'b0111;
                default: s = {STRB_W{1'b1}};
            endcase
        end else begin
            s = {STRB_W{1'b1}};
        end
        return s;
    endfunction

    // Expand a byte strobe into a bit mask over the word.
    function automatic logic [WORD_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
        logic [WORD_W-1:0] m;
        m = {WORD_W{1'b0}};
        for (int i = 0; i < STRB_W; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    assign core_block_o = block_r;

    // Block geometry derived from the remaining byte count and the word position.
    always_comb begin
        if (rem_r > FULL_LIM) begin
            nw_s = 3'd4;
        end else begin
            nw_s = {1'b0, rem_r[3:2]} + {2'b00, |rem_r[1:0]};
        end
        tail_s       = rem_r[1:0];
        last_blk_s   = (rem_r <= BLK_BYTES);
        word_last_s  = (({1'b0, word_cnt_r} + 3'd1) == nw_s);
        next_last_s  = (({1'b0, word_cnt_r} + 3'd2) == nw_s);
        first_last_s = (nw_s == 3'd1);
        in_strb_s    = lane_strb(last_blk_s & word_last_s & (tail_s != 2'd0), tail_s);
        in_word_s    = in_data_i & strb_mask(in_strb_s);
        first_strb_s = lane_strb(last_blk_s & first_last_s & (tail_s != 2'd0), tail_s);
        next_strb_s  = lane_strb(last_blk_s & next_last_s & (tail_s != 2'd0), tail_s);
        // Word k lives in the most significant free slot: slot NWORDS-1-k.
        wr_slot_s    = LAST_SLOT - word_cnt_r;
        rd_slot_s    = LAST_SLOT - word_cnt_r - 2'd1;
        if (rem_r > BLK_BYTES) begin
            rem_nx_s = rem_r - BLK_BYTES;
        end else begin
            rem_nx_s = {CNT_W{1'b0}};
        end
    end

    // Control FSM with registered handshake, pulse and data outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            rem_r        <= {CNT_W{1'b0}};
            word_cnt_r   <= 2'd0;
            block_r      <= '0;
            result_r     <= '0;
            in_ready_o   <= 1'b0;
            core_start_o <= 1'b0;
            out_valid_o  <= 1'b0;
            out_data_o   <= {WORD_W{1'b0}};
            out_strb_o   <= {STRB_W{1'b0}};
            block_done_o <= 1'b0;
            done_o       <= 1'b0;
            busy_o       <= 1'b0;
        end else if (clear) begin
            state_r      <= ST_IDLE;
            rem_r        <= {CNT_W{1'b0}};
            word_cnt_r   <= 2'd0;
            block_r      <= '0;
            result_r     <= '0;
            in_ready_o   <= 1'b0;
            core_start_o <= 1'b0;
            out_valid_o  <= 1'b0;
            out_data_o   <= {WORD_W{1'b0}};
            out_strb_o   <= {STRB_W{1'b0}};
            block_done_o <= 1'b0;
            done_o       <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            core_start_o <= 1'b0;
            block_done_o <= 1'b0;
            done_o       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        rem_r      <= data_size_i;
                        word_cnt_r <= 2'd0;
                        busy_o     <= 1'b1;
                        if (data_size_i == {CNT_W{1'b0}}) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r    <= ST_FILL;
                            in_ready_o <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (in_valid_i && in_ready_o) begin
                        block_r[wr_slot_s] <= in_word_s;
                        if (word_last_s) begin
                            word_cnt_r   <= 2'd0;
                            in_ready_o   <= 1'b0;
                            core_start_o <= 1'b1;
                            state_r      <= ST_CORE_START;
                        end else begin
                            word_cnt_r <= word_cnt_r + 2'd1;
                        end
                    end
                end
                ST_CORE_START: begin
                    state_r <= ST_CORE_WAIT;
                end
                ST_CORE_WAIT: begin
                    if (core_valid_i) begin
                        result_r    <= core_result_i;
                        out_valid_o <= 1'b1;
                        out_data_o  <= core_result_i[BLK_W-1 -: WORD_W];
                        out_strb_o  <= first_strb_s;
                        state_r     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready_i) begin
                        if (word_last_s) begin
                            out_valid_o  <= 1'b0;
                            out_data_o   <= {WORD_W{1'b0}};
                            out_strb_o   <= {STRB_W{1'b0}};
                            block_done_o <= 1'b1;
                            block_r      <= '0;
                            word_cnt_r   <= 2'd0;
                            rem_r        <= rem_nx_s;
                            if (last_blk_s) begin
                                state_r <= ST_DONE;
                            end else begin
                                state_r    <= ST_FILL;
                                in_ready_o <= 1'b1;
                            end
                        end else begin
                            word_cnt_r <= word_cnt_r + 2'd1;
                            out_data_o <= result_r[rd_slot_s];
                            out_strb_o <= next_strb_s;
                        end
                    end
                end
                ST_DONE: begin
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_o  <= 1'b0;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
